// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg -- shared definitions for the program loader.
//   State encoding type and constants, header and word byte counts.
//   Optional feature macro: LOADER_CHECKSUM_EN (enables the CSUM state
//   in prog_loader; the encoding is always defined here).
`timescale 1ns/1ps

package prog_loader_pkg;

    localparam int unsigned HDR_BYTES  = 2;
    localparam int unsigned WORD_BYTES = 4;

    typedef logic [2:0] state_t;

    localparam state_t S_HDR_LO = 3'd0;
    localparam state_t S_HDR_HI = 3'd1;
    localparam state_t S_DATA   = 3'd2;
    localparam state_t S_CSUM   = 3'd3;
    localparam state_t S_DONE   = 3'd4;
    localparam state_t S_ERR    = 3'd5;

endpackage

// File: rtl/prog_loader.sv
// prog_loader -- loads a byte-streamed program into instruction memory and
// holds the cpu in reset until the load completes.
//
// Stream: word count N (2 bytes, LE), N words (4 bytes each, LE), then one
// checksum byte when LOADER_CHECKSUM_EN is defined (data-byte sum plus
// trailer must be 0 mod 256).
//
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset (aborts any load in progress)
//   in_data    : program byte stream
//   in_valid   : in_data valid
//   in_ready   : loader accepts a byte (transfer when in_valid && in_ready)
//   imem_we    : one-cycle write strobe per assembled word
//   imem_addr  : word address for imem_we (BASE_ADDR + index, wraps)
//   imem_wdata : assembled instruction word
//   cpu_rst    : cpu reset, high until the load completes
//   done       : load completed (sticky until rst)
//   error      : load aborted (sticky until rst)
//
// Configuration macro: LOADER_CHECKSUM_EN
`timescale 1ns/1ps

module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              error
);

    localparam int unsigned CNT_W     = 8 * HDR_BYTES;
    localparam logic [1:0]  LAST_BYTE = 2'(WORD_BYTES - 1);
    // Number of words that fit between BASE_ADDR and the top of imem.
    localparam logic [31:0] CAPACITY  = 32'((64'd1 << ADDR_W) - 64'(BASE_ADDR));

    state_t              state_q, state_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [CNT_W-1:0]    widx_q, widx_d;
    logic [23:0]         partial_q, partial_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                in_ready_q, in_ready_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]          sum_q, sum_d;
`endif

    logic                accept;
    logic [CNT_W-1:0]    hdr_n;

    assign accept = in_valid && in_ready_q;
    assign hdr_n  = {in_data, count_q[7:0]};

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        count_d    = count_q;
        widx_d     = widx_q;
        partial_d  = partial_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d      = sum_q;
`endif

        case (state_q)
            S_HDR_LO: begin
                if (accept) begin
                    count_d = CNT_W'(in_data);
                    state_d = S_HDR_HI;
                end
            end

            S_HDR_HI: begin
                if (accept) begin
                    count_d    = hdr_n;
                    widx_d     = '0;
                    byte_cnt_d = '0;
                    if (32'(hdr_n) > CAPACITY) begin
                        state_d = S_ERR;
                    end else if (hdr_n == '0) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = S_CSUM;
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end

            S_DATA: begin
                // All words issued: this is the final word's write-pulse cycle.
                if (widx_q == count_q) begin
                    state_d = S_DONE;
                end else if (accept) begin
`ifdef LOADER_CHECKSUM_EN
                    sum_d = sum_q + in_data;
`endif
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == LAST_BYTE) begin
                        we_d    = 1'b1;
                        addr_d  = ADDR_W'(BASE_ADDR + 32'(widx_q));
                        wdata_d = {in_data, partial_q};
                        widx_d  = widx_q + CNT_W'(1);
`ifdef LOADER_CHECKSUM_EN
                        if (widx_d == count_q) begin
                            state_d = S_CSUM;
                        end
`endif
                    end else begin
                        case (byte_cnt_q)
                            2'd0:    partial_d[7:0]   = in_data;
                            2'd1:    partial_d[15:8]  = in_data;
                            default: partial_d[23:16] = in_data;
                        endcase
                    end
                end
            end

`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (accept) begin
                    state_d = (8'(sum_q + in_data) == 8'h00) ? S_DONE : S_ERR;
                end
            end
`endif

            default: begin
                state_d = state_q;
            end
        endcase

        // Registered ready: dropped during the last word's write pulse so
        // no stray byte is taken before DONE.
        case (state_d)
            S_HDR_LO, S_HDR_HI, S_CSUM: in_ready_d = 1'b1;
            S_DATA:                     in_ready_d = (widx_d != count_d);
            default:                    in_ready_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_HDR_LO;
            byte_cnt_q <= '0;
            count_q    <= '0;
            widx_q     <= '0;
            partial_q  <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            in_ready_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            count_q    <= count_d;
            widx_q     <= widx_d;
            partial_q  <= partial_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            in_ready_q <= in_ready_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    assign in_ready   = in_ready_q;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign cpu_rst    = (state_q != S_DONE);
    assign done       = (state_q == S_DONE);
    assign error      = (state_q == S_ERR);

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader -- directed self-checking bench for prog_loader.
//   dut1: ADDR_W=8, BASE_ADDR=0; dut2: ADDR_W=4, BASE_ADDR=0;
//   dut3: ADDR_W=8, BASE_ADDR=254. All share clk, rst and the byte stream.
//   Checksum scenarios are built when LOADER_CHECKSUM_EN is defined.
`timescale 1ns/1ps

module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;

    logic        rdy1, we1, cr1, dn1, er1;
    logic [7:0]  addr1;
    logic [31:0] wd1;
    logic        rdy2, we2, cr2, dn2, er2;
    logic [3:0]  addr2;
    logic [31:0] wd2;
    logic        rdy3, we3, cr3, dn3, er3;
    logic [7:0]  addr3;
    logic [31:0] wd3;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned we_cnt1 = 0;
    int unsigned we_cnt2 = 0;

    always #5 clk = ~clk;

    prog_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut1 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy1), .imem_we(we1), .imem_addr(addr1), .imem_wdata(wd1),
        .cpu_rst(cr1), .done(dn1), .error(er1)
    );

    prog_loader #(.ADDR_W(4), .BASE_ADDR(0)) dut2 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy2), .imem_we(we2), .imem_addr(addr2), .imem_wdata(wd2),
        .cpu_rst(cr2), .done(dn2), .error(er2)
    );

    prog_loader #(.ADDR_W(8), .BASE_ADDR(254)) dut3 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy3), .imem_we(we3), .imem_addr(addr3), .imem_wdata(wd3),
        .cpu_rst(cr3), .done(dn3), .error(er3)
    );

    always @(negedge clk) begin
        if (we1 === 1'b1) we_cnt1 <= we_cnt1 + 1;
        if (we2 === 1'b1) we_cnt2 <= we_cnt2 + 1;
    end

    function automatic logic rdy_of(input int sel);
        if (sel == 2) return rdy2;
        if (sel == 3) return rdy3;
        return rdy1;
    endfunction

    // Offers one byte after 'gap' idle cycles; returns on the negedge after
    // the accepting rising edge.
    task automatic send_byte(input logic [7:0] b, input int gap, input int sel);
        int n;
        in_valid = 1'b0;
        in_data  = 8'hFF;
        repeat (gap) @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        n = 0;
        while (rdy_of(sel) !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (rdy_of(sel) !== 1'b1) begin
            errors++;
            $display("FAIL send_byte_ready: dut%0d in_ready=%b, required 1 within 20 cycles (byte %h)", sel, rdy_of(sel), b);
        end else begin
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_data  = 8'hFF;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h02;
        repeat (3) @(negedge clk);
        checks++;
        if ({rdy1, we1, addr1, wd1, cr1, dn1, er1} !== {1'b0, 1'b0, 8'd0, 32'd0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b we=%b addr=%h wd=%h cpu_rst=%b done=%b err=%b, required 0 0 00 00000000 1 0 0",
                     rdy1, we1, addr1, wd1, cr1, dn1, er1);
        end
        in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({rdy1, rdy2, rdy3} !== 3'b111) begin
            errors++;
            $display("FAIL ready_after_reset: got %b, required 111", {rdy1, rdy2, rdy3});
        end
    endtask

    task automatic test_two_words();
        do_reset();
        send_byte(8'h02, 0, 1);
        send_byte(8'h00, 0, 1);
        send_byte(8'h13, 0, 1);
        send_byte(8'h00, 0, 1);
        send_byte(8'h10, 0, 1);
        send_byte(8'h00, 0, 1);
        checks++;
        if ({we1, addr1, wd1} !== {1'b1, 8'd0, 32'h00100013}) begin
            errors++;
            $display("FAIL word0_write: got we=%b addr=%h data=%h, required 1 00 00100013", we1, addr1, wd1);
        end
        checks++;
        if ({we3, addr3, wd3} !== {1'b1, 8'd254, 32'h00100013}) begin
            errors++;
            $display("FAIL word0_base_write: got we=%b addr=%h data=%h, required 1 fe 00100013", we3, addr3, wd3);
        end
        send_byte(8'h93, 0, 1);
        send_byte(8'h00, 0, 1);
        send_byte(8'h20, 0, 1);
        send_byte(8'h00, 0, 1);
        checks++;
        if ({we1, addr1, wd1, cr1, dn1} !== {1'b1, 8'd1, 32'h00200093, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL word1_write: got we=%b addr=%h data=%h cpu_rst=%b done=%b, required 1 01 00200093 1 0",
                     we1, addr1, wd1, cr1, dn1);
        end
        checks++;
        if ({we3, addr3, wd3} !== {1'b1, 8'd255, 32'h00200093}) begin
            errors++;
            $display("FAIL word1_base_write: got we=%b addr=%h data=%h, required 1 ff 00200093", we3, addr3, wd3);
        end
`ifdef LOADER_CHECKSUM_EN
        checks++;
        if (rdy1 !== 1'b1) begin
            errors++;
            $display("FAIL csum_ready: got in_ready=%b, required 1", rdy1);
        end
        send_byte(8'h2A, 0, 1);
`else
        checks++;
        if (rdy1 !== 1'b0) begin
            errors++;
            $display("FAIL last_word_ready: got in_ready=%b, required 0", rdy1);
        end
        @(negedge clk);
`endif
        checks++;
        if ({we1, cr1, dn1, er1, rdy1} !== 5'b00100) begin
            errors++;
            $display("FAIL two_words_done: got we,cpu_rst,done,err,rdy=%b, required 00100", {we1, cr1, dn1, er1, rdy1});
        end
        checks++;
        if ({cr3, dn3, er3} !== 3'b010) begin
            errors++;
            $display("FAIL two_words_base_done: got cpu_rst,done,err=%b, required 010", {cr3, dn3, er3});
        end
    endtask

    task automatic test_zero_words();
        int unsigned c;
        do_reset();
        c = we_cnt1;
        send_byte(8'h00, 0, 1);
        send_byte(8'h00, 0, 1);
`ifdef LOADER_CHECKSUM_EN
        checks++;
        if ({dn1, rdy1} !== 2'b01) begin
            errors++;
            $display("FAIL zero_csum_wait: got done,rdy=%b, required 01", {dn1, rdy1});
        end
        send_byte(8'h00, 0, 1);
`endif
        checks++;
        if ({cr1, dn1, rdy1, er1} !== 4'b0100) begin
            errors++;
            $display("FAIL zero_done: got cpu_rst,done,rdy,err=%b, required 0100", {cr1, dn1, rdy1, er1});
        end
        repeat (3) @(negedge clk);
        checks++;
        if (we_cnt1 != c) begin
            errors++;
            $display("FAIL zero_no_write: got %0d writes, required 0", we_cnt1 - c);
        end
    endtask

    task automatic test_overflow();
        int unsigned c2;
        // dut3 holds 2 words (254,255): N=3 overflows; dut1/dut2 accept it.
        do_reset();
        send_byte(8'h03, 0, 1);
        send_byte(8'h00, 0, 1);
        checks++;
        if ({er3, cr3, rdy3, dn3, er1, rdy1, er2} !== 7'b1100010) begin
            errors++;
            $display("FAIL ovf_base: got dut3 err,cpu_rst,rdy,done=%b dut1 err,rdy=%b dut2 err=%b, required 1100 01 0",
                     {er3, cr3, rdy3, dn3}, {er1, rdy1}, er2);
        end
        // ADDR_W=4: N=17 overflows.
        do_reset();
        send_byte(8'h11, 0, 2);
        send_byte(8'h00, 0, 1);
        c2 = we_cnt2;
        checks++;
        if ({er2, cr2, rdy2, dn2} !== 4'b1100) begin
            errors++;
            $display("FAIL ovf_n17: got err,cpu_rst,rdy,done=%b, required 1100", {er2, cr2, rdy2, dn2});
        end
        in_valid = 1'b1;
        in_data  = 8'h5A;
        repeat (6) @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({er2, cr2, rdy2, dn2} !== 4'b1100 || we_cnt2 != c2) begin
            errors++;
            $display("FAIL ovf_sticky: got err,cpu_rst,rdy,done=%b writes=%0d, required 1100 writes=0",
                     {er2, cr2, rdy2, dn2}, we_cnt2 - c2);
        end
        // ADDR_W=4: N=16 fills exactly.
        do_reset();
        send_byte(8'h10, 0, 2);
        send_byte(8'h00, 0, 2);
        checks++;
        if ({er2, rdy2} !== 2'b01) begin
            errors++;
            $display("FAIL fit_n16: got err,rdy=%b, required 01", {er2, rdy2});
        end
        // ADDR_W=8: N=257 overflows, N=256 fits.
        do_reset();
        send_byte(8'h01, 0, 1);
        send_byte(8'h01, 0, 1);
        checks++;
        if ({er1, cr1, rdy1} !== 3'b110) begin
            errors++;
            $display("FAIL ovf_n257: got err,cpu_rst,rdy=%b, required 110", {er1, cr1, rdy1});
        end
        do_reset();
        send_byte(8'h00, 0, 1);
        send_byte(8'h01, 0, 1);
        checks++;
        if ({er1, rdy1} !== 2'b01) begin
            errors++;
            $display("FAIL fit_n256: got err,rdy=%b, required 01", {er1, rdy1});
        end
    endtask

    task automatic test_gaps();
        int unsigned c;
        do_reset();
        send_byte(8'h01, 0, 1);
        send_byte(8'h00, 0, 1);
        c = we_cnt1;
        send_byte(8'hEF, 5, 1);
        send_byte(8'hBE, 5, 1);
        send_byte(8'hAD, 5, 1);
        send_byte(8'hDE, 5, 1);
        checks++;
        if ({we1, addr1, wd1} !== {1'b1, 8'd0, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL gap_write: got we=%b addr=%h data=%h, required 1 00 deadbeef", we1, addr1, wd1);
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'hC8, 5, 1);
`else
        @(negedge clk);
`endif
        @(negedge clk);
        checks++;
        if ({dn1, er1} !== 2'b10 || we_cnt1 != c + 1) begin
            errors++;
            $display("FAIL gap_done: got done,err=%b writes=%0d, required 10 writes=1", {dn1, er1}, we_cnt1 - c);
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        int unsigned c;
        do_reset();
        send_byte(8'h01, 0, 1);
        send_byte(8'h00, 0, 1);
        send_byte(8'h01, 0, 1);
        send_byte(8'h02, 0, 1);
        send_byte(8'h03, 0, 1);
        send_byte(8'h04, 0, 1);
        send_byte(8'hF6, 0, 1);
        checks++;
        if ({dn1, er1, cr1} !== 3'b100) begin
            errors++;
            $display("FAIL csum_good: got done,err,cpu_rst=%b, required 100", {dn1, er1, cr1});
        end
        do_reset();
        c = we_cnt1;
        send_byte(8'h01, 0, 1);
        send_byte(8'h00, 0, 1);
        send_byte(8'h01, 0, 1);
        send_byte(8'h02, 0, 1);
        send_byte(8'h03, 0, 1);
        send_byte(8'h04, 0, 1);
        send_byte(8'hF5, 0, 1);
        @(negedge clk);
        checks++;
        if ({er1, cr1, dn1, rdy1} !== 4'b1100 || we_cnt1 != c + 1) begin
            errors++;
            $display("FAIL csum_bad: got err,cpu_rst,done,rdy=%b writes=%0d, required 1100 writes=1",
                     {er1, cr1, dn1, rdy1}, we_cnt1 - c);
        end
    endtask
`endif

    task automatic test_rst_abort();
        int unsigned c;
        do_reset();
        send_byte(8'h03, 0, 1);
        send_byte(8'h00, 0, 1);
        repeat (4) send_byte(8'h11, 0, 1);
        repeat (4) send_byte(8'h22, 0, 1);
        rst = 1'b1;
        @(negedge clk);
        c = we_cnt1;
        checks++;
        if ({we1, rdy1, cr1} !== 3'b001) begin
            errors++;
            $display("FAIL abort_in_rst: got we,rdy,cpu_rst=%b, required 001", {we1, rdy1, cr1});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_byte(8'h01, 0, 1);
        send_byte(8'h00, 0, 1);
        send_byte(8'h78, 0, 1);
        send_byte(8'h56, 0, 1);
        send_byte(8'h34, 0, 1);
        send_byte(8'h12, 0, 1);
        checks++;
        if ({we1, addr1, wd1, we3, addr3} !== {1'b1, 8'd0, 32'h12345678, 1'b1, 8'd254}) begin
            errors++;
            $display("FAIL reload_write: got we=%b addr=%h data=%h base_we=%b base_addr=%h, required 1 00 12345678 1 fe",
                     we1, addr1, wd1, we3, addr3);
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'hEC, 0, 1);
`else
        @(negedge clk);
`endif
        @(negedge clk);
        checks++;
        if ({dn1, cr1, er1} !== 3'b100 || we_cnt1 != c + 1) begin
            errors++;
            $display("FAIL reload_done: got done,cpu_rst,err=%b writes=%0d, required 100 writes=1",
                     {dn1, cr1, er1}, we_cnt1 - c);
        end
    endtask

    initial begin
        test_reset();
        test_two_words();
        test_zero_words();
        test_overflow();
        test_gaps();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_rst_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within 200000 ns");
        $fatal(1, "timeout");
    end

endmodule
